// File: rtl/vga_text_pkg.sv
// Shared constants for the text-mode renderer: CGA palette, attribute word layout
// and the pixel pipeline depth.
package vga_text_pkg;

    localparam int PIPE_LAT      = 3;
    localparam int ATTR_CHAR_LSB = 0;
    localparam int ATTR_FG_LSB   = 8;
    localparam int ATTR_BG_LSB   = 12;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t CGA_PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic rgb12_t palette_lookup(input logic [3:0] idx);
        return CGA_PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Counts vsync falling edges and toggles the cursor blink phase every
// BLINK_FRAMES frames.
module vga_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic vsync_in,
    output logic blink_state
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_prev;
    logic [CNT_W-1:0] frame_cnt;
    logic             vsync_fall;

    assign vsync_fall = vsync_prev & ~vsync_in;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            vsync_prev  <= 1'b1;
            frame_cnt   <= '0;
            blink_state <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_fall) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_state <= ~blink_state;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_text_renderer.sv
// Three-stage text-mode pixel pipeline: text RAM fetch, font ROM fetch, palette
// and blanking, with syncs delayed to line up with the RGB output.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int CHAR_W_LOG2  = 3,
    parameter int CHAR_H_LOG2  = 4,
    parameter int CURSOR_START = 14,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [15:0] pixel_row,
    input  logic [15:0] pixel_col,
    input  logic        data_rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [4:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    input  logic        cursor_en,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam int CW = CHAR_W_LOG2;
    localparam int CH = CHAR_H_LOG2;
    localparam logic [CH-1:0] CUR_START = CH'(CURSOR_START);

    logic [11:0]   row_cell;
    logic [11:0]   col_cell;
    logic          blink_state;
    logic          cursor_hit;

    logic [CH-1:0] p1_row;
    logic [CW-1:0] p1_col;
    logic          p1_hit;
    logic [CW-1:0] p2_col;
    logic [3:0]    p2_fg;
    logic [3:0]    p2_bg;
    logic          p2_hit;
    logic [CW-1:0] bit_sel;
    logic          pix;

    logic          blank_q1;
    logic          hs_q1, hs_q2;
    logic          vs_q1, vs_q2;
    rgb12_t        rgb_q;

    assign row_cell = 12'(pixel_row >> CH);
    assign col_cell = 12'(pixel_col >> CW);

    generate
        if (COLS == 80) begin : g_addr_shift_add
            assign text_addr = (row_cell << 6) + (row_cell << 4) + col_cell;
        end else begin : g_addr_mul
            assign text_addr = 12'(row_cell * COLS) + col_cell;
        end
    endgenerate

    assign cursor_hit = cursor_en & blink_state
                      & ((pixel_row >> CH) == 16'(cursor_row))
                      & ((pixel_col >> CW) == 16'(cursor_col))
                      & (pixel_row[CH-1:0] >= CUR_START);

    assign font_addr = 12'({text_data[ATTR_CHAR_LSB +: 8], p1_row});

    // Bit 7 is the leftmost pixel, so the glyph column maps to bit (7 - col).
    assign bit_sel = ~p2_col;
    assign pix     = font_data[bit_sel] | p2_hit;

    vga_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .blink_state(blink_state)
    );

    // data_rst already arrives one cycle late; one flop plus the RGB register
    // make its two delay stages, so blanking lands on the same pixel as the syncs.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            p1_row   <= '0;
            p1_col   <= '0;
            p1_hit   <= 1'b0;
            p2_col   <= '0;
            p2_fg    <= '0;
            p2_bg    <= '0;
            p2_hit   <= 1'b0;
            blank_q1 <= 1'b0;
            hs_q1    <= 1'b1;
            hs_q2    <= 1'b1;
            vs_q1    <= 1'b1;
            vs_q2    <= 1'b1;
            rgb_q    <= '0;
        end else begin
            p1_row   <= pixel_row[CH-1:0];
            p1_col   <= pixel_col[CW-1:0];
            p1_hit   <= cursor_hit;
            p2_col   <= p1_col;
            p2_fg    <= text_data[ATTR_FG_LSB +: 4];
            p2_bg    <= text_data[ATTR_BG_LSB +: 4];
            p2_hit   <= p1_hit;
            blank_q1 <= data_rst;
            hs_q1    <= hsync_in;
            hs_q2    <= hs_q1;
            vs_q1    <= vsync_in;
            vs_q2    <= vs_q1;
            rgb_q    <= blank_q1 ? '0 : palette_lookup(pix ? p2_fg : p2_bg);
        end
    end

    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];
    assign vga_hsync = hs_q2;
    assign vga_vsync = vs_q2;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Randomized bench for vga_text_renderer against a per-pixel behavioural model
// of the text screen, plus directed glyph, address, blanking and cursor cases.
module tb_vga_text_renderer;
    import vga_text_pkg::*;

    localparam int BF      = 2;
    localparam int OUT_OFS = PIPE_LAT - 1;

    localparam logic [11:0] PAL_REF [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic [15:0] pixel_row, pixel_col;
    logic        data_rst, hsync_in, vsync_in;
    logic [11:0] text_addr, font_addr;
    logic [15:0] text_data;
    logic [7:0]  font_data;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        cursor_en;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;

    always #5 pixel_clk = ~pixel_clk;

    vga_text_renderer #(
        .COLS(80), .CHAR_W_LOG2(3), .CHAR_H_LOG2(4),
        .CURSOR_START(14), .BLINK_FRAMES(BF)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .pixel_row (pixel_row),
        .pixel_col (pixel_col),
        .data_rst  (data_rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .text_addr (text_addr),
        .text_data (text_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .cursor_en (cursor_en),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync)
    );

    logic [15:0] text_ram [4096];
    logic [7:0]  font_rom [4096];

    always @(posedge pixel_clk) begin
        text_data <= text_ram[text_addr];
        font_data <= font_rom[font_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic blank_fn(input int r, input int c);
        return (c >= 640) || (r >= 480);
    endfunction

    function automatic logic hs_fn(input int r, input int c);
        return !(c >= 656 && c < 752);
    endfunction

    function automatic logic vs_fn(input int r, input int c);
        return !(r >= 490 && r < 492);
    endfunction

    function automatic int exp_addr(input int r, input int c);
        return ((r / 16) * 80 + (c / 8)) % 4096;
    endfunction

    function automatic logic [11:0] model_rgb(input int r, input int c, input logic ce,
                                              input int cr, input int cc, input int nfalls);
        logic [15:0] w;
        logic [7:0]  g;
        logic        on, hit;
        if (blank_fn(r, c)) return 12'h000;
        w   = text_ram[exp_addr(r, c)];
        g   = font_rom[int'(w[7:0]) * 16 + r % 16];
        on  = g[7 - c % 8];
        hit = ce && ((nfalls / BF) % 2 == 1) && (r / 16 == cr) && (c / 8 == cc) && (r % 16 >= 14);
        return PAL_REF[(on || hit) ? w[11:8] : w[15:12]];
    endfunction

    // model state: cycle index, edges since reset release, vsync falls seen
    int   cyc = 0;
    int   since = 0;
    int   falls = 0;
    logic prev_vs = 1'b1;
    logic [11:0] exp_rgb [65536];
    logic        exp_hs  [65536];
    logic        exp_vs  [65536];
    logic [11:0] out_rgb [65536];
    logic        out_hs  [65536];

    always @(posedge pixel_clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            since   <= 0;
            falls   <= 0;
            prev_vs <= 1'b1;
        end else begin
            exp_rgb[cyc & 16'hFFFF] <= model_rgb(pixel_row, pixel_col, cursor_en,
                                                 cursor_row, cursor_col, falls);
            exp_hs[cyc & 16'hFFFF]  <= hs_fn(pixel_row, pixel_col);
            exp_vs[cyc & 16'hFFFF]  <= vs_fn(pixel_row, pixel_col);
            since <= since + 1;
            if (prev_vs && !vsync_in) falls <= falls + 1;
            prev_vs <= vsync_in;
        end
    end

    always @(negedge pixel_clk) begin
        int m, e;
        logic [11:0] rgb;
        m   = (cyc - 1) & 16'hFFFF;
        rgb = {vga_r, vga_g, vga_b};
        out_rgb[m] <= rgb;
        out_hs[m]  <= vga_hsync;
        chk("text_addr", text_addr, exp_addr(pixel_row, pixel_col));
        if (rst) begin
            chk("rst_rgb", rgb, 0);
            chk("rst_hsync", vga_hsync, 1);
            chk("rst_vsync", vga_vsync, 1);
        end else if (since >= PIPE_LAT) begin
            e = (m - OUT_OFS) & 16'hFFFF;
            chk("rgb", rgb, exp_rgb[e]);
            chk("hsync", vga_hsync, exp_hs[e]);
            chk("vsync", vga_vsync, exp_vs[e]);
        end
    end

    int cur_r = 0;
    int cur_c = 0;

    task automatic set_pix(input int r, input int c);
        @(posedge pixel_clk);
        #1;
        data_rst  = blank_fn(cur_r, cur_c);
        hsync_in  = hs_fn(cur_r, cur_c);
        vsync_in  = vs_fn(cur_r, cur_c);
        pixel_row = 16'(r);
        pixel_col = 16'(c);
        cur_r = r;
        cur_c = c;
    endtask

    task automatic vsync_pulse();
        set_pix(490, 0);
        set_pix(491, 0);
        set_pix(0, 0);
        set_pix(0, 0);
    endtask

    task automatic cell_row(input string name, input int r, input logic [11:0] exp);
        int s;
        set_pix(r, 40);
        s = cyc;
        for (int k = 1; k < 8; k++) set_pix(r, 40 + k);
        repeat (4) set_pix(0, 0);
        for (int k = 0; k < 8; k++) chk(name, out_rgb[(s + k + OUT_OFS) & 16'hFFFF], exp);
    endtask

    initial begin
        int s, nz, lows;
        rst = 1'b1;
        cursor_en = 1'b0; cursor_row = '0; cursor_col = '0;
        pixel_row = 16'd10; pixel_col = 16'd300;
        data_rst = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        cur_r = 10; cur_c = 300;
        for (int i = 0; i < 4096; i++) begin
            text_ram[i] = 16'($urandom);
            font_rom[i] = 8'($urandom);
        end
        text_ram[0]        = 16'hF141;
        font_rom[12'h410]  = 8'h81;
        text_ram[165]      = 16'h1400;
        font_rom[12'h00D]  = 8'h00;
        font_rom[12'h00E]  = 8'h00;
        font_rom[12'h00F]  = 8'h00;

        // reset held mid-line, then a single glyph row
        repeat (5) set_pix(10, 300);
        rst = 1'b0;
        set_pix(0, 0);
        s = cyc;
        for (int k = 1; k < 8; k++) set_pix(0, k);
        repeat (4) set_pix(1, 0);
        for (int k = 0; k < 8; k++)
            chk("glyph_px", out_rgb[(s + k + OUT_OFS) & 16'hFFFF], (k == 0 || k == 7) ? 12'h00A : 12'hFFF);

        set_pix(17, 25);
        #1 chk("addr_17_25", text_addr, 83);
        set_pix(479, 639);
        #1 chk("addr_479_639", text_addr, 2399);

        // full line sweep for blanking and hsync timing
        set_pix(200, 0);
        s = cyc;
        for (int k = 1; k < 800; k++) set_pix(200, k);
        repeat (4) set_pix(201, 0);
        nz = 0;
        lows = 0;
        for (int k = 0; k < 800; k++) begin
            if (k >= 640 && out_rgb[(s + k + OUT_OFS) & 16'hFFFF] != 12'h000) nz++;
            if (out_hs[(s + k + OUT_OFS) & 16'hFFFF] == 1'b0) lows++;
        end
        chk("blank_cols_nonzero", nz, 0);
        chk("hsync_low_cycles", lows, 96);
        chk("hsync_first_low", out_hs[(s + 656 + OUT_OFS) & 16'hFFFF], 0);
        chk("hsync_before_low", out_hs[(s + 655 + OUT_OFS) & 16'hFFFF], 1);

        // asynchronous reset while hsync output is low
        for (int c = 660; c < 680; c++) set_pix(200, c);
        chk("hsync_low_pre_rst", vga_hsync, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_hsync", vga_hsync, 1);
        chk("async_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        cursor_en = 1'b1; cursor_row = 5'd2; cursor_col = 7'd5;
        repeat (5) set_pix(200, 300);
        rst = 1'b0;

        // cursor blink
        cell_row("cursor_off", 46, 12'h00A);
        vsync_pulse(); vsync_pulse();
        cell_row("cursor_on_r46", 46, 12'hA00);
        cell_row("cursor_on_r47", 47, 12'hA00);
        cell_row("cursor_r45_glyph", 45, 12'h00A);
        vsync_pulse(); vsync_pulse();
        cell_row("cursor_blink_off", 46, 12'h00A);
        vsync_pulse(); vsync_pulse();
        cell_row("cursor_on_again", 46, 12'hA00);
        rst = 1'b1;
        repeat (3) set_pix(46, 40);
        rst = 1'b0;
        cell_row("cursor_after_rst", 46, 12'h00A);
        vsync_pulse();
        cell_row("cursor_one_frame", 46, 12'h00A);
        vsync_pulse();
        cell_row("cursor_restart", 46, 12'hA00);

        // randomized traffic
        for (int it = 0; it < 1200; it++) begin
            int mode, r, c, len;
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                cursor_en  = ($urandom_range(0, 3) != 0);
                cursor_row = 5'($urandom_range(0, 31));
                cursor_col = 7'($urandom_range(0, 127));
            end
            if (mode <= 3) begin
                r   = int'(cursor_row) * 16 + $urandom_range(12, 15);
                c   = (int'(cursor_col) * 8 >= 4) ? int'(cursor_col) * 8 - 4 : 0;
                len = 16;
            end else if (mode == 4) begin
                r   = $urandom_range(486, 494);
                c   = $urandom_range(0, 799);
                len = $urandom_range(1, 6);
            end else if (mode == 5) begin
                r   = $urandom_range(0, 65535);
                c   = $urandom_range(0, 1023);
                len = $urandom_range(1, 10);
            end else begin
                r   = $urandom_range(0, 524);
                c   = $urandom_range(0, 799);
                len = $urandom_range(1, 30);
            end
            for (int k = 0; k < len; k++) set_pix(r, c + k);
            if (it == 600) begin
                rst = 1'b1;
                repeat (2) set_pix(r, c);
                rst = 1'b0;
            end
        end
        repeat (6) set_pix(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Text-mode pixel generator that sits directly downstream of the VGA sync generator on the pixel clock.
- Consumes pixel_row, pixel_col, data_rst, vga_hsync and vga_vsync from that generator.
- Fetches character/attribute words from text RAM and glyph rows from font ROM, and drives 4:4:4 RGB with sync outputs re-aligned to the pixel pipeline.
- Also draws a blinking hardware cursor.

Parameters:
COLS, 80, character cells per text row
CHAR_W_LOG2, 3, glyph width = 8 px
CHAR_H_LOG2, 4, glyph height = 16 px
CURSOR_START, 14, first glyph scanline of the underline cursor
BLINK_FRAMES, 30, frames per cursor blink phase

Ports:
pixel_clk  in  1  pixel clock, single clock domain
rst  in  1  asynchronous active-high reset
pixel_row  in  16  current row from sync generator
pixel_col  in  16  current column from sync generator
data_rst  in  1  blanking from sync generator (registered, lags row/col by 1 cycle)
hsync_in  in  1  active-low hsync from sync generator (lags row/col by 1)
vsync_in  in  1  active-low vsync from sync generator (lags row/col by 1)
text_addr  out  12  text RAM word address (combinational)
text_data  in  16  text RAM read data, [7:0]=char code, [11:8]=fg index, [15:12]=bg index; valid 1 cycle after address
font_addr  out  12  font ROM address {char, glyph_row}
font_data  in  8  font ROM row, bit 7 = leftmost pixel; valid 1 cycle after address
cursor_row  in  5  cursor cell row
cursor_col  in  7  cursor cell column
cursor_en  in  1  cursor visible
vga_r, vga_g, vga_b  out  4 each  colour outputs (registered)
vga_hsync  out  1  delayed hsync
vga_vsync  out  1  delayed vsync

Behaviour:
- Clock and reset: one clock, pixel_clk; rst is asynchronous and active-high. While rst is high, every register clears immediately:
  - RGB = 0, vga_hsync = 1, vga_vsync = 1.
  - Pipeline registers 0, blink counter 0, blink_state 0.
- Reset mid-frame: outputs take reset values without waiting for a clock edge. The first valid pixel appears 3 edges after release.
- Stage 0 (combinational):
  - text_addr = (pixel_row>>4)*COLS + (pixel_col>>3), truncated to 12 bits. For COLS=80, implement as shift-add (x64 + x16).
  - Out-of-visible addresses are still issued; they are masked later.
  - cursor_hit = cursor_en & blink_state & (row>>4 == cursor_row) & (col>>3 == cursor_col) & (row[3:0] >= CURSOR_START).
- Edge E1: register p1 = {row[3:0], col[2:0], cursor_hit}.
- Stage 1 (combinational): font_addr = {text_data[7:0], p1.row[3:0]}.
- Edge E2: register p2 = {col[2:0], fg, bg, cursor_hit}.
- Stage 2 (combinational): pix = font_data[7 - p2.col] | p2.cursor_hit.
- Edge E3: RGB <= blank_d ? 0 : palette(pix ? fg : bg).
- Latency: pixel_row/col to RGB is exactly 3 edges.
- Sync alignment:
  - hsync_in, vsync_in and data_rst each pass through a 2-stage delay, giving 3 cycles total from row/col.
  - blank_d is the 2-delayed data_rst; vga_hsync/vga_vsync are the 2-delayed inputs.
  - Output syncs are therefore exactly 2 edges behind the input syncs.
- Blink:
  - Detect vsync_in falling edge (1→0) using a registered previous value that resets to 1.
  - On each edge, the frame counter increments. When it equals BLINK_FRAMES-1 it wraps to 0 and blink_state toggles.
  - The counter is wide enough for BLINK_FRAMES-1.
- Palette: fixed 16-entry CGA table from the package (index 0 = 000, 7 = AAA, 15 = FFF, etc.).
- Boundary conditions:
  - Columns 640..800 and rows 480+ produce black through blanking.
  - A cursor cell outside the screen is never drawn.
  - A cursor_row/col change takes effect at the next pixel sampled in stage 0.

Decomposition:
- Package vga_text_pkg holds:
  - the 16-entry 12-bit palette constant and palette lookup function;
  - attribute field offsets and the PIPE_LAT=3 constant.
- One sub-module, vga_blink_timer: vsync edge detect, frame counter and blink_state, parameterised by BLINK_FRAMES.

Test Plan:
- Reset and release: hold rst for 5 cycles mid-line, release → RGB=0 and syncs=1 during reset; first non-blank RGB appears 3 edges after row/col=(0,0).
- Single glyph: text RAM[0]=0xF141 ('A', fg=1, bg=F), font row 0=0x81 → at row 0, cols 0 and 7 output palette(1)=00A; cols 1–6 output FFF; each 3 cycles after the column.
- Address math: row=17, col=25 → text_addr=1*80+3=83; row=479, col=639 → text_addr=29*80+79=2399.
- Blanking alignment: drive data_rst/hsync_in with the generator's 1-cycle lag → RGB=0 exactly for cols 640..800 after the 3-cycle shift; vga_hsync low 96 cycles, 2 edges after hsync_in.
- Cursor blink: cursor_en=1 at (2,5), BLINK_FRAMES=2 → after 2 vsync falling edges, cells rows 46–47 cols 40–47 show fg; after 2 more, glyph only.
- Reset mid-blink: assert rst with blink_state=1 → cursor disappears; counter restarts at 0.
